// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler for the DDS core.
// Steps the phase increment P from f_start to f_stop in f_step increments,
// holds each value for `dwell` clocks, repeats for n_sweeps sweeps (0 means
// run until abort), then flushes the DDS pipeline and pulses done.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | outputs parked at zero, waiting for a start with a legal config
//   RUN   | P stepping, accumulator enabled, samples marked valid
//   FLUSH | P held, accumulator still enabled, valid low while the DDS
//         | pipeline drains for PIPE clocks
module dds_sweep_ctrl #(
    parameter int M    = 27,
    parameter int DW   = 16,
    parameter int NW   = 8,
    parameter int PIPE = 4
) (
    input  logic          clk,
    input  logic          rst_ac,
    input  logic          start,
    input  logic          abort,
    input  logic [M-1:0]  f_start,
    input  logic [M-1:0]  f_stop,
    input  logic [M-1:0]  f_step,
    input  logic [DW-1:0] dwell,
    input  logic [NW-1:0] n_sweeps,
    output logic [M-1:0]  P,
    output logic          ena_ac,
    output logic          val_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] sweep_cnt
);

    // Flush counter is sized for PIPE-1 down to 0; keep at least one bit.
    localparam int FW = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(PIPE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;

    // Configuration captured on a legal start; the live inputs may change
    // freely while a run is in progress.
    logic [M-1:0]  f_start_r;
    logic [M-1:0]  f_stop_r;
    logic [M-1:0]  f_step_r;
    logic [DW-1:0] dwell_r;
    logic [NW-1:0] n_sweeps_r;

    logic [DW-1:0] dwell_cnt;
    logic [FW-1:0] flush_cnt;

    logic          cfg_legal;
    logic [M:0]    p_next;
    logic          step_ok;
    logic [NW-1:0] sweep_nxt;
    logic          last_sweep;

    // Start-time config check, done on the live inputs.
    assign cfg_legal = (f_step != '0) && (f_stop >= f_start) && (dwell != '0);

    // Next step is formed one bit wider so an overflow past 2^M compares as
    // "beyond f_stop" instead of wrapping to a small increment.
    assign p_next  = {1'b0, P} + {1'b0, f_step_r};
    assign step_ok = (p_next <= {1'b0, f_stop_r});

    // Sweep bookkeeping; wraps naturally in continuous mode.
    assign sweep_nxt  = sweep_cnt + NW'(1);
    assign last_sweep = (n_sweeps_r != '0) && (sweep_nxt == n_sweeps_r);

    // Sequencer: state, config latch, timers and all registered outputs.
    always_ff @(posedge clk or posedge rst_ac) begin
        if (rst_ac) begin
            state      <= IDLE;
            f_start_r  <= '0;
            f_stop_r   <= '0;
            f_step_r   <= '0;
            dwell_r    <= '0;
            n_sweeps_r <= '0;
            dwell_cnt  <= '0;
            flush_cnt  <= '0;
            P          <= '0;
            ena_ac     <= 1'b0;
            val_in     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sweep_cnt  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            f_start_r  <= f_start;
                            f_stop_r   <= f_stop;
                            f_step_r   <= f_step;
                            dwell_r    <= dwell;
                            n_sweeps_r <= n_sweeps;
                            P          <= f_start;
                            ena_ac     <= 1'b1;
                            val_in     <= 1'b1;
                            busy       <= 1'b1;
                            sweep_cnt  <= '0;
                            dwell_cnt  <= dwell - DW'(1);
                            state      <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        // Abort wins over any step or sweep end this cycle.
                        val_in    <= 1'b0;
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end else if (step_ok) begin
                        P         <= p_next[M-1:0];
                        dwell_cnt <= dwell_r - DW'(1);
                    end else begin
                        sweep_cnt <= sweep_nxt;
                        if (last_sweep) begin
                            val_in    <= 1'b0;
                            flush_cnt <= FLUSH_LOAD;
                            state     <= FLUSH;
                        end else begin
                            // Accumulator keeps running so phase stays continuous.
                            P         <= f_start_r;
                            dwell_cnt <= dwell_r - DW'(1);
                        end
                    end
                end

                FLUSH: begin
                    if (flush_cnt == '0) begin
                        ena_ac <= 1'b0;
                        P      <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed sweep scenarios checked every cycle against a
// queue of expected output samples built from the sweep rules.
module tb_dds_sweep_ctrl;

    localparam int M    = 27;
    localparam int DW   = 16;
    localparam int NW   = 8;
    localparam int PIPE = 4;

    logic          clk;
    logic          rst_ac;
    logic          start;
    logic          abort;
    logic [M-1:0]  f_start;
    logic [M-1:0]  f_stop;
    logic [M-1:0]  f_step;
    logic [DW-1:0] dwell;
    logic [NW-1:0] n_sweeps;
    logic [M-1:0]  P;
    logic          ena_ac;
    logic          val_in;
    logic          busy;
    logic          done;
    logic          err;
    logic [NW-1:0] sweep_cnt;

    dds_sweep_ctrl #(.M(M), .DW(DW), .NW(NW), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst_ac    (rst_ac),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .n_sweeps  (n_sweeps),
        .P         (P),
        .ena_ac    (ena_ac),
        .val_in    (val_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt)
    );

    typedef struct {
        logic [M-1:0]  p;
        logic          ena;
        logic          val;
        logic          bsy;
        logic          dn;
        logic          er;
        logic [NW-1:0] sc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          snap[$];
    exp_t          e_c;
    logic [NW-1:0] hold_sc;
    int            n_vec;
    int            n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(longint p, bit ena, bit val, bit bsy, bit dn, bit er, int sc);
        exp_t e;
        e.p   = p[M-1:0];
        e.ena = ena;
        e.val = val;
        e.bsy = bsy;
        e.dn  = dn;
        e.er  = er;
        e.sc  = sc[NW-1:0];
        return e;
    endfunction

    // Expected samples, one per clock after the start edge. abort_at is the
    // RUN-cycle index during which abort is held (-1: never).
    task automatic gen(longint fs, longint fe, longint fst, int dw, int ns, int abort_at);
        int     idx = 0;
        int     s = 0;
        bit     stop = 0;
        longint p;
        longint last_p = 0;
        while (!stop) begin
            p = fs;
            while (p <= fe && !stop) begin
                for (int k = 0; k < dw && !stop; k++) begin
                    exp_q.push_back(mk(p, 1, 1, 1, 0, 0, s));
                    last_p = p;
                    if (idx == abort_at) stop = 1;
                    idx++;
                end
                if (!stop) p = p + fst;
            end
            if (!stop) begin
                s++;
                if (ns != 0 && s == ns) stop = 1;
            end
        end
        for (int k = 0; k < PIPE; k++) exp_q.push_back(mk(last_p, 1, 0, 1, 0, 0, s));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, s));
        hold_sc = s[NW-1:0];
    endtask

    task automatic pin(string name, longint act, longint expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    task automatic wait_drain(int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain-timeout: %0d samples left, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Launch a run; optionally abort, poke start, or reset at a RUN-cycle index.
    task automatic run(longint fs, longint fe, longint fst, int dw, int ns,
                       int ab, int pk, int rs);
        int last;
        f_start  = fs[M-1:0];
        f_stop   = fe[M-1:0];
        f_step   = fst[M-1:0];
        dwell    = dw[DW-1:0];
        n_sweeps = ns[NW-1:0];
        start    = 1'b1;
        @(negedge clk);
        #1;
        gen(fs, fe, fst, dw, ns, ab);
        snap = exp_q;
        @(posedge clk);
        #1;
        start = 1'b0;
        last = ab;
        if (pk > last) last = pk;
        if (rs > last) last = rs;
        for (int c = 0; c <= last; c++) begin
            if (c == rs) begin
                #2;
                rst_ac = 1'b1;
                exp_q.delete();
                hold_sc = '0;
                #1;
                pin("rst_async_P", P, 0);
                pin("rst_async_ena", ena_ac, 0);
                pin("rst_async_val", val_in, 0);
                pin("rst_async_busy", busy, 0);
                @(posedge clk);
                #1;
                rst_ac = 1'b0;
                break;
            end
            if (c == ab) abort = 1'b1;
            if (c == pk) begin
                start    = 1'b1;
                f_start  = 27'd7;
                f_step   = 27'd1;
                dwell    = 16'd9;
                n_sweeps = 8'd3;
            end
            @(posedge clk);
            #1;
            abort = 1'b0;
            start = 1'b0;
        end
        wait_drain(600);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint bad_fs[3] = '{100, 400, 100};
        longint bad_fe[3] = '{400, 100, 400};
        longint bad_st[3] = '{0, 100, 100};
        int     bad_dw[3] = '{3, 3, 0};

        n_vec    = 0;
        n_err    = 0;
        hold_sc  = '0;
        rst_ac   = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        f_start  = '0;
        f_stop   = '0;
        f_step   = '0;
        dwell    = '0;
        n_sweeps = '0;

        fork
            forever begin
                @(negedge clk);
                if (exp_q.size() != 0) e_c = exp_q.pop_front();
                else e_c = mk(0, 0, 0, 0, 0, 0, int'(hold_sc));
                n_vec++;
                if ({P, ena_ac, val_in, busy, done, err, sweep_cnt} !==
                    {e_c.p, e_c.ena, e_c.val, e_c.bsy, e_c.dn, e_c.er, e_c.sc}) begin
                    n_err++;
                    $display("FAIL cycle t=%0t: got P=%0d ena=%b val=%b busy=%b done=%b err=%b cnt=%0d; want P=%0d ena=%b val=%b busy=%b done=%b err=%b cnt=%0d",
                             $time, P, ena_ac, val_in, busy, done, err, sweep_cnt,
                             e_c.p, e_c.ena, e_c.val, e_c.bsy, e_c.dn, e_c.er, e_c.sc);
                end
            end
        join_none

        #1;
        pin("reset_P", P, 0);
        pin("reset_ena", ena_ac, 0);
        pin("reset_busy", busy, 0);
        pin("reset_cnt", sweep_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ac = 1'b0;
        @(posedge clk);
        #1;

        // Single sweep, dwell 3.
        run(100, 400, 100, 3, 1, -1, -1, -1);
        pin("t1_len", snap.size(), 17);
        pin("t1_p2", snap[2].p, 100);
        pin("t1_p3", snap[3].p, 200);
        pin("t1_p11", snap[11].p, 400);
        pin("t1_flush_val", snap[12].val, 0);
        pin("t1_done", snap[16].dn, 1);

        // Two sweeps: 400 followed directly by 100.
        run(100, 400, 100, 3, 2, -1, -1, -1);
        pin("t2_len", snap.size(), 29);
        pin("t2_wrap_p", snap[12].p, 100);
        pin("t2_wrap_ena", snap[12].ena, 1);
        pin("t2_end_cnt", snap[28].sc, 2);

        // Top of range: step would overflow 2^27.
        run(134217528, 134217727, 150, 1, 1, -1, -1, -1);
        pin("t3_len", snap.size(), 7);
        pin("t3_p1", snap[1].p, 134217678);
        pin("t3_flush_p", snap[2].p, 134217678);

        // Continuous, aborted on the 5th RUN clock.
        run(100, 400, 100, 3, 0, 4, -1, -1);
        pin("t4_len", snap.size(), 10);
        pin("t4_flush_p", snap[5].p, 200);
        pin("t4_done", snap[9].dn, 1);

        // Illegal configs: err pulse only.
        for (int i = 0; i < 3; i++) begin
            f_start  = bad_fs[i][M-1:0];
            f_stop   = bad_fe[i][M-1:0];
            f_step   = bad_st[i][M-1:0];
            dwell    = bad_dw[i][DW-1:0];
            n_sweeps = 8'd1;
            start    = 1'b1;
            @(negedge clk);
            #1;
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, int'(hold_sc)));
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_drain(10);
        end

        // start pulsed mid-RUN with a different config is ignored.
        run(100, 400, 100, 3, 1, -1, 5, -1);

        // Continuous single-point sweeps: sweep_cnt wraps past 255.
        run(100, 100, 1, 1, 0, 259, -1, -1);
        pin("t6_len", snap.size(), 265);
        pin("t6_cnt255", snap[255].sc, 255);
        pin("t6_cnt_wrap", snap[256].sc, 0);
        pin("t6_done_cnt", snap[264].sc, 3);

        // Reset between edges mid-RUN, then a clean restart.
        run(100, 400, 100, 3, 1, -1, -1, 6);
        run(100, 400, 100, 3, 1, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
